// File: rtl/x_mux_nto1_pkg.sv
// rtl/x_mux_nto1_pkg.sv - shared state encoding and counter sizing for the N-to-1 serializer
package x_mux_nto1_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mux_state_t;

  // Slice counter width; never narrower than one bit so RATIO=1 still has a counter.
  function automatic int cnt_width(input int ratio);
    return (ratio <= 2) ? 1 : $clog2(ratio);
  endfunction

endpackage

// File: rtl/x_mux_slice_sel.sv
// rtl/x_mux_slice_sel.sv - picks the slice to emit from a frame given the slice counter
module x_mux_slice_sel
  import x_mux_nto1_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter int RATIO     = 2,
  parameter bit LSB_FIRST = 1'b1,
  localparam int CW       = cnt_width(RATIO)
) (
  input  logic [RATIO*WIDTH-1:0] frame,
  input  logic [CW-1:0]          cnt,
  output logic [WIDTH-1:0]       slice
);

  // Counter value 0 always means "first slice sent"; LSB_FIRST only remaps which slice that is.
  always_comb begin
    slice = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (cnt == CW'(LSB_FIRST ? k : RATIO - 1 - k)) begin
        slice = frame[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/x_mux_nto1.sv
// rtl/x_mux_nto1.sv - N-to-1 output serializer with hold buffer, frame marker and underrun flag
module x_mux_nto1
  import x_mux_nto1_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter int               RATIO     = 2,
  parameter logic [WIDTH-1:0] IDLE_VAL  = {WIDTH{1'b1}},
  parameter bit               LSB_FIRST = 1'b1
) (
  input  logic                   clock,
  input  logic                   nreset,
  input  logic                   clock_en,
  input  logic [RATIO*WIDTH-1:0] din,
  input  logic                   din_valid,
  output logic                   din_ready,
  input  logic                   blank,
  input  logic                   noe,
  output logic [WIDTH-1:0]       dout,
  output logic                   dout_oe,
  output logic                   dout_first,
  output logic                   underrun,
  input  logic                   underrun_clr
);

  localparam int            CW   = cnt_width(RATIO);
  localparam int            FW   = RATIO * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  mux_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [FW-1:0]   shift_q, shift_d;
  logic [FW-1:0]   hold_q, hold_d;
  logic            hold_full_q, hold_full_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic            first_q, first_d;
  logic            oe_q, oe_d;
  logic            underrun_q, underrun_d;
  logic [WIDTH-1:0] slice_d;
  logic            at_end;
  logic            accept;
  logic            set_ur;

  // cnt_q tracks the slice currently on dout, so at_end marks the frame boundary decision.
  assign at_end    = (state_q == ST_RUN) && (cnt_q == LAST);
  assign din_ready = nreset & clock_en & ~blank & (~hold_full_q | (at_end & hold_full_q));
  assign accept    = din_valid & din_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    first_d     = first_q;
    oe_d        = oe_q;
    underrun_d  = underrun_q;
    set_ur      = 1'b0;
    if (clock_en) begin
      oe_d = ~noe;
      if (blank) begin
        state_d     = ST_IDLE;
        cnt_d       = '0;
        shift_d     = '0;
        hold_d      = '0;
        hold_full_d = 1'b0;
        first_d     = 1'b0;
      end else if (state_q == ST_IDLE) begin
        first_d = 1'b0;
        if (accept) begin
          shift_d = din;
          cnt_d   = '0;
          state_d = ST_RUN;
          first_d = 1'b1;
        end
      end else if (!at_end) begin
        cnt_d   = cnt_q + CW'(1);
        first_d = 1'b0;
        if (accept) begin
          hold_d      = din;
          hold_full_d = 1'b1;
        end
      end else begin
        // Frame boundary: hold has priority, then a direct accept, else we ran dry.
        cnt_d   = '0;
        first_d = 1'b1;
        if (hold_full_q) begin
          shift_d     = hold_q;
          hold_full_d = accept;
          if (accept) begin
            hold_d = din;
          end
        end else if (accept) begin
          shift_d = din;
        end else begin
          state_d = ST_IDLE;
          first_d = 1'b0;
          set_ur  = 1'b1;
        end
      end
      underrun_d = set_ur | (underrun_q & ~underrun_clr);
    end
  end

  x_mux_slice_sel #(
    .WIDTH     (WIDTH),
    .RATIO     (RATIO),
    .LSB_FIRST (LSB_FIRST)
  ) u_slice_sel (
    .frame (shift_d),
    .cnt   (cnt_d),
    .slice (slice_d)
  );

  assign dout_d = !clock_en ? dout_q : ((state_d == ST_RUN) ? slice_d : IDLE_VAL);

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      dout_q      <= IDLE_VAL;
      first_q     <= 1'b0;
      oe_q        <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      dout_q      <= dout_d;
      first_q     <= first_d;
      oe_q        <= oe_d;
      underrun_q  <= underrun_d;
    end
  end

  assign dout       = dout_q;
  assign dout_first = first_q;
  assign dout_oe    = oe_q;
  assign underrun   = underrun_q;

endmodule
